control_multiciclo: RTL and testbench
=====================================

// Module: control_multiciclo
// PURPOSE
//  Multi-cycle sequencer for the RV32 subset datapath: PC, IR, register file, ALU, data memory.
//  It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and issues every write-enable,
//  mux select and memory request.
//  Instruction and data share one memory port. That port's variable latency is handled with a
//  req/ready handshake guarded by a timeout.
//  Supported opcodes: LUI, JAL, BRANCH (BNE/BGE), LOAD, STORE, OP-IMM.
//  Any other opcode, or a memory timeout, traps the core.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready before TRAP (>=1)
//  RET_W        32  width of retired-instruction counter
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  opcode        in   7      IR[6:0], valid from DECODE onward
//  funct3        in   3      IR[14:12], passed through for ALUControl
//  branch_taken  in   1      ALU comp result, sampled in EXEC
//  mem_ready     in   1      memory completes the current request this cycle
//  pc_we         out  1      PC load strobe
//  pc_src        out  2      00 PC+4, 01 branch target, 10 jump target
//  ir_we         out  1      IR load strobe
//  reg_we        out  1      register-file write strobe
//  mem_req       out  1      memory request; held until mem_ready
//  mem_we        out  1      1 = write (store); valid only with mem_req
//  mem_is_instr  out  1      1 = address from PC, 0 = address from ALU result
//  alu_op        out  3      000 LUI/JAL, 001 BR, 010 LD, 011 ST, 100 OP-IMM
//  alu_src       out  1      1 = immediate operand
//  mem_to_reg    out  1      1 = WB data from memory
//  state         out  3      current state encoding (debug)
//  trap          out  1      sticky; 1 = illegal opcode or timeout
//  trap_cause    out  1      0 = illegal opcode, 1 = memory timeout
//  retired       out  RET_W  count of completed instructions, wraps at 2^RET_W
// BEHAVIOUR
//  Reset (reset low, any time, asynchronous):
//   - State goes to FETCH; retired, trap, trap_cause, op_q and timeout counter clear.
//   - All strobes (pc_we, ir_we, reg_we, mem_req, mem_we) are forced 0 while reset is low.
//   - The first mem_req rises in the first cycle after reset deasserts.
//  Outputs are combinational from state and op_q (Moore). Strobes are single-cycle, except mem_req.
//  FETCH:
//   - Drive mem_req=1, mem_is_instr=1.
//   - On mem_ready: ir_we=1, go to DECODE. Otherwise stay.
//  DECODE:
//   - Register opcode into op_q.
//   - Legal opcode: go to EXEC. Illegal: go to TRAP with cause 0.
//  EXEC (alu_op and alu_src come from op_q):
//   - LUI / OP-IMM: go to WB.
//   - LOAD / STORE: go to MEM.
//   - BRANCH: pc_we=1, pc_src = branch_taken ? 01 : 00, retire, go to FETCH.
//   - JAL: pc_we=1, pc_src=10, retire, go to FETCH. No link register write.
//  MEM:
//   - Drive mem_req=1, mem_is_instr=0, mem_we = (op_q==STORE); alu_op stays valid.
//   - On mem_ready, STORE: pc_we=1, pc_src=00, retire, go to FETCH.
//   - On mem_ready, LOAD: go to WB.
//  WB:
//   - reg_we=1, mem_to_reg = (op_q==LOAD), pc_we=1, pc_src=00, retire, go to FETCH.
//  TRAP:
//   - All strobes 0; state held until reset. opcode and mem_ready are ignored.
//  Timeout:
//   - Counter clears on entry to FETCH or MEM and counts each cycle mem_req=1 && !mem_ready.
//   - When it reaches MEM_TIMEOUT with no ready: go to TRAP, cause 1.
//   - mem_ready in the same cycle as the limit still completes normally (ready wins).
//  Retire: retired increments by 1 on every pc_we; it wraps from all-ones to 0.
//  Latency with mem_ready=1 on first request cycle:
//   - BR / JAL: 3 cycles.
//   - LUI / OP-IMM / ST: 4 cycles.
//   - LD: 5 cycles.
//  mem_ready outside FETCH/MEM is ignored.
// STRUCTURE
//  Package riscv_ctrl_pkg holds:
//   - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
//   - Opcode constants (0110111, 1101111, 1100011, 0000011, 0100011, 0010011).
//   - ALUop constants and pc_src constants.
//  Sub-module: contador_timeout (load/clear, enable, terminal-count flag, MEM_TIMEOUT param).
//  The FSM next-state and output decode stay in this module.
// TESTING
//  - LUI x1 with ready immediate -> strobes ir_we@c1, reg_we+pc_we@c4, retired=1, pc_src=00.
//  - BNE with branch_taken=1 -> pc_we@c3 with pc_src=01; with taken=0 -> pc_src=00; no reg_we.
//  - LW with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0,
//    then WB with mem_to_reg=1, reg_we=1; 8 cycles total.
//  - SW -> mem_we=1 with mem_req in MEM, pc_we on ready; reg_we never asserted.
//  - Opcode 0110011 -> DECODE->TRAP, trap=1, cause=0; all strobes 0 for 20 cycles;
//    release via reset -> FETCH.
//  - mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> TRAP, cause=1 after 16 cycles.
//    Ready at cycle 16 -> no trap.
//    Reset pulsed mid-MEM -> mem_req drops asynchronously; retired=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32-subset sequencer: states, opcodes,
// ALU operation codes and PC source selects.
package riscv_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] ALU_LUI_JAL = 3'b000;
  localparam logic [2:0] ALU_BR      = 3'b001;
  localparam logic [2:0] ALU_LD      = 3'b010;
  localparam logic [2:0] ALU_ST      = 3'b011;
  localparam logic [2:0] ALU_IMM     = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
  } alu_ctl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_JAL) || (op == OP_BRANCH) ||
           (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IMM);
  endfunction

  // Branch compares two registers; every other supported opcode uses the immediate.
  function automatic alu_ctl_t alu_decode(input logic [6:0] op);
    alu_ctl_t c;
    c.alu_op  = ALU_LUI_JAL;
    c.alu_src = 1'b1;
    case (op)
      OP_BRANCH: begin
        c.alu_op  = ALU_BR;
        c.alu_src = 1'b0;
      end
      OP_LOAD:  c.alu_op = ALU_LD;
      OP_STORE: c.alu_op = ALU_ST;
      OP_IMM:   c.alu_op = ALU_IMM;
      default:  c.alu_op = ALU_LUI_JAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Memory-wait counter: clears on request, counts stalled cycles and flags the
// cycle in which the wait reaches MEM_TIMEOUT.
module contador_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted while stalling with MEM_TIMEOUT-1 cycles already counted.
  assign o_tc = i_en && (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, shared memory
// port handshake with timeout, sticky trap and retired-instruction counter.
module control_multiciclo
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_instr,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             trap,
  output logic             trap_cause,
  output logic [RET_W-1:0] retired
);

  logic [2:0]       r_state, w_state_next;
  logic [6:0]       r_op_q;
  logic             r_trap_cause, w_cause_next;
  logic [RET_W-1:0] r_retired;
  logic             w_pc_we, w_ir_we, w_reg_we, w_mem_req;
  logic [1:0]       w_pc_src;
  logic             w_tmo_clr, w_tmo_en, w_tmo_tc;
  alu_ctl_t         w_alu;
  logic             w_unused_funct3;

  // funct3 is consumed by the ALU control, not by the sequencer.
  assign w_unused_funct3 = ^funct3;

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_trap_cause;
    w_pc_we      = 1'b0;
    w_pc_src     = PC_PLUS4;
    w_ir_we      = 1'b0;
    w_reg_we     = 1'b0;
    w_mem_req    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_tmo_tc) begin
          w_state_next = S_TRAP;
          w_cause_next = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(opcode)) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_TRAP;
          w_cause_next = 1'b0;
        end
      end
      S_EXEC: begin
        case (r_op_q)
          OP_LUI, OP_IMM:    w_state_next = S_WB;
          OP_LOAD, OP_STORE: w_state_next = S_MEM;
          OP_BRANCH: begin
            w_pc_we      = 1'b1;
            w_pc_src     = branch_taken ? PC_BRANCH : PC_PLUS4;
            w_state_next = S_FETCH;
          end
          OP_JAL: begin
            w_pc_we      = 1'b1;
            w_pc_src     = PC_JUMP;
            w_state_next = S_FETCH;
          end
          default: begin
            w_state_next = S_TRAP;
            w_cause_next = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          if (r_op_q == OP_STORE) begin
            w_pc_we      = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_tmo_tc) begin
          w_state_next = S_TRAP;
          w_cause_next = 1'b1;
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_pc_we      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_TRAP: w_state_next = S_TRAP;
      default: w_state_next = S_TRAP;
    endcase
  end

  // Any state change clears the wait counter, so each FETCH/MEM entry starts fresh.
  assign w_tmo_clr = (w_state_next != r_state);
  assign w_tmo_en  = w_mem_req && !mem_ready;

  contador_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .i_clr(w_tmo_clr),
    .i_en (w_tmo_en),
    .o_tc (w_tmo_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_op_q       <= '0;
      r_trap_cause <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_trap_cause <= w_cause_next;
      if (r_state == S_DECODE) begin
        r_op_q <= opcode;
      end
      if (w_pc_we) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign w_alu = alu_decode(r_op_q);

  // Strobes are gated by reset so they drop immediately, not at the next edge.
  assign pc_we        = w_pc_we && reset;
  assign ir_we        = w_ir_we && reset;
  assign reg_we       = w_reg_we && reset;
  assign mem_req      = w_mem_req && reset;
  assign mem_we       = (r_state == S_MEM) && (r_op_q == OP_STORE) && reset;
  assign pc_src       = w_pc_src;
  assign mem_is_instr = (r_state == S_FETCH);
  assign alu_op       = w_alu.alu_op;
  assign alu_src      = w_alu.alu_src;
  assign mem_to_reg   = (r_state == S_WB) && (r_op_q == OP_LOAD);
  assign state        = r_state;
  assign trap         = (r_state == S_TRAP);
  assign trap_cause   = r_trap_cause;
  assign retired      = r_retired;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: per-instruction phase model built from the
// instruction rules, a table of hand vectors, random programs and trap/reset cases.
module tb_control_multiciclo;

  localparam int TMO = 16;
  localparam int RW  = 4;

  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] BAD = 7'b0110011;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = 3'b001;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_we, ir_we, reg_we, mem_req, mem_we, mem_is_instr;
  logic          alu_src, mem_to_reg, trap, trap_cause;
  logic [1:0]    pc_src;
  logic [2:0]    alu_op, state;
  logic [RW-1:0] retired;

  control_multiciclo #(.MEM_TIMEOUT(TMO), .RET_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr),
    .alu_op(alu_op), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, ir, pcwe, regwe;
    logic [1:0] pcsrc;
    logic       mwe, instr, m2r, alu;
    logic [2:0] aop;
    logic       asrc, srck;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         fw, mw;
    int         cyc, regwe, memreq, memwe;
    logic [1:0] src;
  } vec_t;

  int checks = 0, errors = 0;
  int exp_ret = 0;
  logic exp_cause = 1'b0;
  int obs_n, obs_pcwe_at, obs_regwe, obs_memreq, obs_memwe;
  logic [1:0] obs_src;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance to next negedge.
  task automatic step(input logic rdy, input cyc_t e, input string nm);
    mem_ready = rdy;
    #1;
    obs_n++;
    chk({nm, ".state"},   32'(state),   32'(e.st));
    chk({nm, ".mem_req"}, 32'(mem_req), 32'(e.mreq));
    chk({nm, ".ir_we"},   32'(ir_we),   32'(e.ir));
    chk({nm, ".pc_we"},   32'(pc_we),   32'(e.pcwe));
    chk({nm, ".reg_we"},  32'(reg_we),  32'(e.regwe));
    chk({nm, ".mem_we"},  32'(mem_we),  32'(e.mreq & e.mwe));
    chk({nm, ".trap"},    32'(trap),    32'(e.st == 3'd7));
    chk({nm, ".cause"},   32'(trap_cause), 32'(exp_cause));
    chk({nm, ".retired"}, 32'(retired), 32'(exp_ret));
    if (e.pcwe)  chk({nm, ".pc_src"}, 32'(pc_src), 32'(e.pcsrc));
    if (e.mreq)  chk({nm, ".mem_is_instr"}, 32'(mem_is_instr), 32'(e.instr));
    if (e.regwe) chk({nm, ".mem_to_reg"}, 32'(mem_to_reg), 32'(e.m2r));
    if (e.alu) begin
      chk({nm, ".alu_op"}, 32'(alu_op), 32'(e.aop));
      if (e.srck) chk({nm, ".alu_src"}, 32'(alu_src), 32'(e.asrc));
    end
    if (pc_we === 1'b1) begin
      obs_pcwe_at = obs_n;
      obs_src     = pc_src;
    end
    if (reg_we === 1'b1) obs_regwe++;
    if (mem_req === 1'b1) obs_memreq++;
    if (mem_req === 1'b1 && mem_we === 1'b1) obs_memwe++;
    if (e.pcwe) exp_ret = (exp_ret + 1) % (1 << RW);
    @(negedge clk);
  endtask

  function automatic cyc_t fetch_c(input logic last);
    cyc_t e = '0;
    e.st = 3'd0; e.mreq = 1'b1; e.instr = 1'b1; e.ir = last;
    return e;
  endfunction

  function automatic cyc_t trap_c();
    cyc_t e = '0;
    e.st = 3'd7;
    return e;
  endfunction

  // Expected behaviour of one instruction, phase by phase.
  task automatic run_instr(input logic [6:0] op, input logic tk, input int fw, input int mw);
    cyc_t e;
    logic [2:0] aop;
    logic asrc, srck, legal;
    legal = 1'b1; srck = 1'b1; asrc = 1'b1; aop = 3'b000;
    case (op)
      LUI: aop = 3'b000;
      JAL: srck = 1'b0;
      BR:  begin aop = 3'b001; asrc = 1'b0; end
      LD:  aop = 3'b010;
      ST:  aop = 3'b011;
      IMM: aop = 3'b100;
      default: legal = 1'b0;
    endcase
    opcode = op; branch_taken = tk;
    obs_n = 0; obs_pcwe_at = 0; obs_src = 2'b11; obs_regwe = 0; obs_memreq = 0; obs_memwe = 0;
    for (int k = 0; k <= fw; k++) step(k == fw, fetch_c(k == fw), "fetch");
    e = '0; e.st = 3'd1;
    step(1'($urandom), e, "decode");
    if (legal) begin
      e = '0; e.st = 3'd2; e.alu = 1'b1; e.aop = aop; e.asrc = asrc; e.srck = srck;
      if (op == BR) begin e.pcwe = 1'b1; e.pcsrc = tk ? 2'b01 : 2'b00; end
      if (op == JAL) begin e.pcwe = 1'b1; e.pcsrc = 2'b10; end
      step(1'($urandom), e, "exec");
      if (op == LD || op == ST) begin
        for (int k = 0; k <= mw; k++) begin
          e = '0; e.st = 3'd3; e.mreq = 1'b1; e.mwe = (op == ST);
          e.alu = 1'b1; e.aop = aop; e.asrc = asrc; e.srck = 1'b1;
          e.pcwe = (op == ST) && (k == mw);
          step(k == mw, e, "mem");
        end
      end
      if (op == LUI || op == IMM || op == LD) begin
        e = '0; e.st = 3'd4; e.regwe = 1'b1; e.m2r = (op == LD); e.pcwe = 1'b1;
        e.alu = 1'b1; e.aop = aop; e.asrc = asrc; e.srck = 1'b1;
        step(1'($urandom), e, "wb");
      end
    end
    $display("instr op=%b taken=%0d fw=%0d mw=%0d cycles=%0d retired=%0d",
             op, tk, fw, mw, obs_n, retired);
  endtask

  // Called right after a negedge: pulse reset asynchronously, mid-cycle.
  task automatic do_reset(input string nm);
    #2 reset = 1'b0;
    #1;
    chk({nm, ".rst_state"},   32'(state),   32'd0);
    chk({nm, ".rst_mem_req"}, 32'(mem_req), 32'd0);
    chk({nm, ".rst_pc_we"},   32'(pc_we),   32'd0);
    chk({nm, ".rst_retired"}, 32'(retired), 32'd0);
    chk({nm, ".rst_trap"},    32'(trap),    32'd0);
    chk({nm, ".rst_cause"},   32'(trap_cause), 32'd0);
    exp_ret = 0; exp_cause = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vt[8];
  logic [6:0] legal_ops[6];
  cyc_t em;

  initial begin
    vt[0] = '{LUI, 1'b0, 0, 0, 4, 1, 1, 0, 2'b00};
    vt[1] = '{BR,  1'b1, 0, 0, 3, 0, 1, 0, 2'b01};
    vt[2] = '{BR,  1'b0, 0, 0, 3, 0, 1, 0, 2'b00};
    vt[3] = '{LD,  1'b0, 0, 3, 8, 1, 5, 0, 2'b00};
    vt[4] = '{ST,  1'b0, 0, 2, 6, 0, 4, 3, 2'b00};
    vt[5] = '{JAL, 1'b0, 0, 0, 3, 0, 1, 0, 2'b10};
    vt[6] = '{IMM, 1'b0, 2, 0, 6, 1, 3, 0, 2'b00};
    vt[7] = '{LD,  1'b0, 1, 0, 6, 1, 3, 0, 2'b00};
    legal_ops = '{LUI, JAL, BR, LD, ST, IMM};

    repeat (2) @(negedge clk);
    chk("reset.state",   32'(state),   32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.ir_we",   32'(ir_we),   32'd0);
    chk("reset.pc_we",   32'(pc_we),   32'd0);
    chk("reset.reg_we",  32'(reg_we),  32'd0);
    chk("reset.mem_we",  32'(mem_we),  32'd0);
    chk("reset.retired", 32'(retired), 32'd0);
    chk("reset.trap",    32'(trap),    32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_instr(vt[i].op, vt[i].taken, vt[i].fw, vt[i].mw);
      chk($sformatf("vec%0d.latency", i), 32'(obs_pcwe_at), 32'(vt[i].cyc));
      chk($sformatf("vec%0d.pc_src", i),  32'(obs_src),     32'(vt[i].src));
      chk($sformatf("vec%0d.reg_we_n", i), 32'(obs_regwe),  32'(vt[i].regwe));
      chk($sformatf("vec%0d.mem_req_n", i), 32'(obs_memreq), 32'(vt[i].memreq));
      chk($sformatf("vec%0d.mem_we_n", i), 32'(obs_memwe),  32'(vt[i].memwe));
    end

    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4));

    // Ready on the very last permitted cycle completes normally.
    run_instr(LUI, 1'b0, TMO - 1, 0);
    run_instr(LD, 1'b0, 0, TMO - 1);

    // Illegal opcode: trap with cause 0, then ignore all inputs.
    run_instr(BAD, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      opcode = 7'($urandom);
      step(1'($urandom), trap_c(), "illegal_trap");
    end
    do_reset("illegal");

    // Fetch that never completes: TMO request cycles, then trap with cause 1.
    opcode = LUI;
    for (int i = 0; i < TMO; i++) step(1'b0, fetch_c(1'b0), "fetch_wait");
    exp_cause = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, trap_c(), "timeout_trap");
    do_reset("timeout");

    // Reset asserted while a load waits in MEM.
    run_instr(JAL, 1'b0, 0, 0);
    opcode = LD;
    step(1'b1, fetch_c(1'b1), "mid.fetch");
    em = '0; em.st = 3'd1;
    step(1'b0, em, "mid.decode");
    em = '0; em.st = 3'd2; em.alu = 1'b1; em.aop = 3'b010; em.asrc = 1'b1; em.srck = 1'b1;
    step(1'b0, em, "mid.exec");
    em = '0; em.st = 3'd3; em.mreq = 1'b1; em.alu = 1'b1; em.aop = 3'b010; em.asrc = 1'b1; em.srck = 1'b1;
    step(1'b0, em, "mid.mem");
    step(1'b0, em, "mid.mem");
    do_reset("midmem");
    run_instr(LUI, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
